// File: rtl/instruction_fetcher.sv
// instruction_fetcher
//   Fetches one instruction word at pc from instruction memory and presents it
//   until the controller drops the fetch. The most recent successful fetch is
//   kept in a single-entry buffer so that a repeat fetch of the same word
//   completes in one cycle without touching memory. A fetch whose read data
//   does not arrive within TIMEOUT_CYCLES cycles of waiting completes with
//   instr=0 and fetch_error=1.
//
// Ports
//   clk               in   clock, all state updates on the rising edge
//   reset             in   asynchronous active-high reset
//   fetcher_reset     in   high = abort / stay idle, low = fetch at pc
//   pc[31:0]          in   fetch address (pc[1:0] ignored)
//   buf_invalidate    in   discard the last-fetch buffer
//   fetcher_completed out  high while a fetched instruction is presented
//   instr[31:0]       out  fetched instruction word
//   fetch_error       out  high with fetcher_completed when the fetch timed out
//   mem_req           out  memory read request
//   mem_addr[31:0]    out  word-aligned read address
//   mem_ack           in   request accepted when mem_req & mem_ack
//   mem_rvalid        in   read data valid, once per accepted request
//   mem_rdata[31:0]   in   read data
module instruction_fetcher #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetcher_reset,
    input  logic [31:0] pc,
    input  logic        buf_invalidate,
    output logic        fetcher_completed,
    output logic [31:0] instr,
    output logic        fetch_error,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;

    logic        buf_valid;
    logic [29:0] buf_pc;
    logic [31:0] buf_instr;
    logic        pending;
    logic [9:0]  wait_cnt;

    logic        buf_hit;
    logic        hit_taken;
    logic        resp_taken;
    logic        timed_out;
    logic        start_req;

    // Byte offset bits are deliberately ignored.
    logic        pc_lsb_unused;
    assign pc_lsb_unused = ^pc[1:0];

    assign buf_hit    = buf_valid && (buf_pc == pc[31:2]);
    assign hit_taken  = !fetcher_reset && (state == IDLE) && buf_hit;
    assign start_req  = !fetcher_reset && (state == IDLE) && !buf_hit && !pending;
    // Read data is used only when it completes the live fetch; anything else
    // (aborted or timed-out request) merely retires the pending flag.
    assign resp_taken = !fetcher_reset && mem_rvalid &&
                        ((state == WAIT) || ((state == REQ) && mem_ack));
    assign timed_out  = !fetcher_reset && (state == WAIT) && !mem_rvalid &&
                        (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (fetcher_reset) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (buf_hit) begin
                        next_state = DONE;
                    end else if (!pending) begin
                        next_state = REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        next_state = mem_rvalid ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid || (wait_cnt == WAIT_LAST)) begin
                        next_state = DONE;
                    end
                end
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        mem_req           = 1'b0;
        fetcher_completed = 1'b0;
        case (state)
            REQ:     mem_req = 1'b1;
            DONE:    fetcher_completed = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            fetch_error <= 1'b0;
            mem_addr    <= '0;
            buf_valid   <= 1'b0;
            buf_pc      <= '0;
            buf_instr   <= '0;
            pending     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (hit_taken) begin
                instr <= buf_instr;
            end else if (resp_taken) begin
                instr <= mem_rdata;
            end else if (timed_out) begin
                instr <= '0;
            end

            if (timed_out) begin
                fetch_error <= 1'b1;
            end else if (next_state != DONE) begin
                fetch_error <= 1'b0;
            end

            if (start_req) begin
                mem_addr <= {pc[31:2], 2'b00};
            end

            if (resp_taken) begin
                buf_pc    <= pc[31:2];
                buf_instr <= mem_rdata;
            end

            if (buf_invalidate) begin
                buf_valid <= 1'b0;
            end else if (resp_taken) begin
                buf_valid <= 1'b1;
            end

            // Same-cycle accept and data leaves nothing outstanding.
            if (mem_rvalid) begin
                pending <= 1'b0;
            end else if (mem_req && mem_ack) begin
                pending <= 1'b1;
            end

            wait_cnt <= (state == WAIT) ? wait_cnt + 10'd1 : '0;
        end
    end

endmodule
